// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One Booth digit per cycle, valid/ready handshake on both sides.
module booth_mul_seq #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN / 2 + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int EW = XLEN + 2;
  localparam int MW = XLEN + 3;
  localparam int AW = XLEN + 4;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [MW-1:0]   mul_q, mul_d;
  logic [EW-1:0]   a_q, a_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            sgn1, sgn2;
  logic [EW-1:0]   rs1_ext, rs2_ext;
  logic [AW-1:0]   a_sx, a2, pp, sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] res_sel;

  always_comb begin
    sgn1    = (i_op != 2'b11) & i_rs1[XLEN-1];
    sgn2    = ~i_op[1] & i_rs2[XLEN-1];
    rs1_ext = {{2{sgn1}}, i_rs1};
    rs2_ext = {{2{sgn2}}, i_rs2};
  end

  always_comb begin
    a_sx = {{2{a_q[EW-1]}}, a_q};
    a2   = {a_sx[AW-2:0], 1'b0};
    pp   = '0;
    unique case (mul_q[2:0])
      3'b001, 3'b010: pp = a_sx;
      3'b011:         pp = a2;
      3'b100:         pp = -a2;
      3'b101, 3'b110: pp = -a_sx;
      default:        pp = '0;
    endcase
    sum = acc_q + pp;
  end

  // Product sits one bit above the appended Booth zero.
  always_comb begin
    prod    = {acc_q[XLEN-3:0], mul_q[MW-1:1]};
    res_sel = (op_q == 2'b00) ? prod[XLEN-1:0]
                              : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mul_d   = mul_q;
    a_d     = a_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          mul_d   = {rs2_ext, 1'b0};
          a_d     = rs1_ext;
          op_d    = i_op;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(ITER)) begin
          res_d   = res_sel;
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
          mul_d = {sum[1:0], mul_q[MW-1:2]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mul_q   <= '0;
      a_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mul_q   <= mul_d;
      a_q     <= a_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: products, latency,
// backpressure, flush and async reset.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mul_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input  logic [1:0]  op,
                        input  logic [31:0] a,
                        input  logic [31:0] b,
                        output logic [31:0] res,
                        output int          lat);
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op    = 2'($urandom);
    i_rs1   = $urandom;
    i_rs2   = $urandom;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = o_result;
  endtask

  task automatic pop();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  logic [1:0]  v_op  [9];
  logic [31:0] v_a   [9];
  logic [31:0] v_b   [9];
  logic [31:0] v_exp [9];

  initial begin
    logic [31:0] res;
    int lat;
    int seen;

    v_op[0] = 2'b01; v_a[0] = 32'h80000000; v_b[0] = 32'h80000000; v_exp[0] = 32'h40000000;
    v_op[1] = 2'b00; v_a[1] = 32'h80000000; v_b[1] = 32'h80000000; v_exp[1] = 32'h00000000;
    v_op[2] = 2'b01; v_a[2] = 32'hFFFFFFFF; v_b[2] = 32'hFFFFFFFF; v_exp[2] = 32'h00000000;
    v_op[3] = 2'b11; v_a[3] = 32'hFFFFFFFF; v_b[3] = 32'hFFFFFFFF; v_exp[3] = 32'hFFFFFFFE;
    v_op[4] = 2'b10; v_a[4] = 32'hFFFFFFFF; v_b[4] = 32'hFFFFFFFF; v_exp[4] = 32'hFFFFFFFF;
    v_op[5] = 2'b10; v_a[5] = 32'h00000002; v_b[5] = 32'h80000000; v_exp[5] = 32'h00000001;
    v_op[6] = 2'b00; v_a[6] = 32'h0000FFFF; v_b[6] = 32'h0000FFFF; v_exp[6] = 32'hFFFE0001;
    v_op[7] = 2'b01; v_a[7] = 32'hFFFFFFFF; v_b[7] = 32'h00000002; v_exp[7] = 32'hFFFFFFFF;
    v_op[8] = 2'b11; v_a[8] = 32'h80000000; v_b[8] = 32'h00000002; v_exp[8] = 32'h00000001;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_rs1   = '0;
    i_rs2   = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    #1;
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_result", o_result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'd7, 32'hFFFFFFFD, res, lat);
    check_eq("mul_lat", 32'(lat), 32'd18);
    check_eq("mul_7x-3", res, 32'hFFFFFFEB);
    pop();
    check_eq("pop_ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], res, lat);
      check_eq($sformatf("vec%0d_lat", i), 32'(lat), 32'd18);
      check_eq($sformatf("vec%0d_res", i), res, v_exp[i]);
      pop();
    end

    run_op(2'b00, 32'd3, 32'd5, res, lat);
    check_eq("bp_res", res, 32'h0000000F);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", 32'(o_valid), 32'd1);
      check_eq("bp_result", o_result, 32'h0000000F);
      check_eq("bp_ready", 32'(o_ready), 32'd0);
    end
    pop();
    check_eq("bp_ready_after", 32'(o_ready), 32'd1);
    check_eq("bp_valid_after", 32'(o_valid), 32'd0);
    run_op(2'b11, 32'hFFFFFFFF, 32'd2, res, lat);
    check_eq("b2b_lat", 32'(lat), 32'd18);
    check_eq("b2b_res", res, 32'h00000001);
    pop();

    @(negedge clk);
    i_valid = 1'b1;
    i_op    = 2'b00;
    i_rs1   = 32'd3;
    i_rs2   = 32'd5;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check_eq("flush_ready", 32'(o_ready), 32'd1);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    check_eq("flush_noval", 32'(seen), 32'd0);

    @(negedge clk);
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    check_eq("flush_idle_ready", 32'(o_ready), 32'd1);

    run_op(2'b00, 32'd3, 32'd5, res, lat);
    check_eq("post_flush_lat", 32'(lat), 32'd18);
    check_eq("post_flush_res", res, 32'h0000000F);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check_eq("flush_done_valid", 32'(o_valid), 32'd0);
    check_eq("flush_done_ready", 32'(o_ready), 32'd1);

    @(negedge clk);
    i_valid = 1'b1;
    i_op    = 2'b01;
    i_rs1   = 32'h12345678;
    i_rs2   = 32'h7FFFFFFF;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_ready", 32'(o_ready), 32'd1);
    check_eq("arst_valid", 32'(o_valid), 32'd0);
    check_eq("arst_result", o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    check_eq("arst_noval", 32'(seen), 32'd0);

    run_op(2'b11, 32'h00010000, 32'h00010000, res, lat);
    check_eq("arst_mulhu_lat", 32'(lat), 32'd18);
    check_eq("arst_mulhu_res", res, 32'h00000001);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
